// File: rtl/cnn_pkg.sv
// Shared sizes, derived constants and state type for the pooled feature-map buffer.
package cnn_pkg;

    localparam int NUM_CH  = 16;
    localparam int DATA_W  = 8;
    localparam int MAX_COL = 12;
    localparam int COLS    = MAX_COL + 1;
    localparam int PIX_CNT = COLS * COLS;
    localparam int ADDR_W  = 8;
    localparam int IDX_W   = 5;
    localparam int WORD_W  = NUM_CH * DATA_W;
    localparam int RD_W    = 2 * WORD_W;

    localparam logic [IDX_W-1:0]  MAX_IDX  = IDX_W'(MAX_COL);
    localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] PIX_A    = ADDR_W'(PIX_CNT);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SERVE
    } fb_state_t;

    // Raster pixel address; wraps for out-of-range indices, which the caller masks.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        return ADDR_W'(row) * COLS_A + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/feature_map_buffer_if.sv
// Pooling-stage write and dense-layer read signals of the feature-map buffer.
interface feature_map_buffer_if;
    import cnn_pkg::*;

    logic              wr_valid;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ready;
    logic              map_ready;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_row;
    logic [IDX_W-1:0]  rd_col;
    logic [IDX_W-1:0]  rd_chan;
    logic [RD_W-1:0]   rd_data;
    logic              rd_valid;
    logic              frame_done;
    logic              err;

    modport master (
        output wr_valid, wr_data, rd_en, rd_row, rd_col, rd_chan,
        input  wr_ready, map_ready, rd_data, rd_valid, frame_done, err
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, rd_row, rd_col, rd_chan,
        output wr_ready, map_ready, rd_data, rd_valid, frame_done, err
    );

endinterface

// File: rtl/fb_ram.sv
// Pixel store: one synchronous write port, two synchronous read ports (pixel and its right neighbour).
module fb_ram
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WORD_W-1:0] q0,
    output logic [WORD_W-1:0] q1
);

    logic [WORD_W-1:0] mem [PIX_CNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read registers only move on a read so the dense side sees held data between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q0 <= '0;
            q1 <= '0;
        end else if (re) begin
            q0 <= (raddr0 < PIX_A) ? mem[raddr0] : '0;
            q1 <= (raddr1 < PIX_A) ? mem[raddr1] : '0;
        end
    end

endmodule

// File: rtl/feature_map_buffer.sv
// Captures a pooled feature map, then serves pixel pairs to the dense layer until its last read.
// Optional sticky protocol error flag built only when FEATBUF_ERR_EN is defined.
//
// state | meaning
// IDLE  | empty, waiting for pixel 0
// FILL  | storing pixels in raster order
// SERVE | map complete, answering dense-layer reads
module feature_map_buffer
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    feature_map_buffer_if.slave  bus
);

    fb_state_t         state, state_nxt;
    logic [ADDR_W-1:0] wcnt, wcnt_nxt;

    logic              wr_ready;
    logic              wr_fire;
    logic              rd_fire;
    logic              in_range;
    logic              final_rd;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_nb;
    logic [WORD_W-1:0] q0, q1;
    logic [RD_W-1:0]   rd_word;

    logic              rd_valid_q;
    logic              frame_done_q;
    logic              lo_zero_q;
    logic              hi_zero_q;

    assign wr_ready   = (state != SERVE);
    assign wr_fire    = bus.wr_valid && wr_ready;
    assign rd_fire    = bus.rd_en && (state == SERVE);
    assign in_range   = (bus.rd_row <= MAX_IDX) && (bus.rd_col <= MAX_IDX);
    assign rd_addr    = pix_addr(bus.rd_row, bus.rd_col);
    assign rd_addr_nb = rd_addr + ADDR_W'(1);
    assign final_rd   = rd_fire && (bus.rd_row == MAX_IDX) && (bus.rd_col == MAX_IDX)
                        && (bus.rd_chan == LAST_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    state_nxt = FILL;
                    wcnt_nxt  = wcnt + ADDR_W'(1);
                end
            end
            FILL: begin
                if (wr_fire) begin
                    if (wcnt == LAST_PIX) begin
                        state_nxt = SERVE;
                        wcnt_nxt  = '0;
                    end else begin
                        wcnt_nxt = wcnt + ADDR_W'(1);
                    end
                end
            end
            SERVE: begin
                if (final_rd) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                wcnt_nxt  = '0;
            end
        endcase
    end

    fb_ram u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_fire),
        .waddr  (wcnt),
        .wdata  (bus.wr_data),
        .re     (rd_fire),
        .raddr0 (rd_addr),
        .raddr1 (rd_addr_nb),
        .q0     (q0),
        .q1     (q1)
    );

    // Masks travel with the read so the returned pair matches the address that was asked for.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            lo_zero_q    <= 1'b0;
            hi_zero_q    <= 1'b0;
        end else begin
            rd_valid_q   <= rd_fire;
            frame_done_q <= final_rd;
            if (rd_fire) begin
                lo_zero_q <= !in_range;
                hi_zero_q <= !in_range || (bus.rd_col == MAX_IDX);
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_word[c*2*DATA_W +: DATA_W]          = lo_zero_q ? '0 : q0[c*DATA_W +: DATA_W];
            rd_word[c*2*DATA_W + DATA_W +: DATA_W] = hi_zero_q ? '0 : q1[c*DATA_W +: DATA_W];
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.map_ready  = (state == SERVE);
    assign bus.rd_data    = rd_word;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.frame_done = frame_done_q;

`ifdef FEATBUF_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((bus.wr_valid && (state == SERVE)) ||
                     (bus.rd_en && (state != SERVE)) ||
                     (bus.rd_en && !in_range)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_feature_map_buffer.sv
// Randomized self-checking bench for feature_map_buffer against an array model of the stored map.
module tb_feature_map_buffer;
    import cnn_pkg::*;

`ifdef FEATBUF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    logic [DATA_W-1:0] mdl [PIX_CNT][NUM_CH];

    feature_map_buffer_if bus();

    feature_map_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [RD_W-1:0] exp_rd(input int row, input int col);
        logic [RD_W-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (row <= MAX_COL && col <= MAX_COL)
                v[c*2*DATA_W +: DATA_W] = mdl[row*COLS + col][c];
            if (row <= MAX_COL && col < MAX_COL)
                v[c*2*DATA_W + DATA_W +: DATA_W] = mdl[row*COLS + col + 1][c];
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
        checks++; if (bus.map_ready !== 1'b0) begin errors++; $display("FAIL reset_map_ready got %b want 0", bus.map_ready); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
    endtask

    // mode 0: pattern (p+c) mod 128 with continuous valid; 1: random data, valid every other cycle;
    // 2: random data, continuous valid. Stops after 'limit' accepted pixels.
    task automatic fill(input int mode, input int limit);
        int n = 0;
        int cyc = 0;
        int ready_bad = 0;
        logic v, acc;
        logic [WORD_W-1:0] d;
        while (n < limit && cyc < 2000 && !bus.map_ready) begin
            v = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            for (int c = 0; c < NUM_CH; c++)
                d[c*DATA_W +: DATA_W] = (mode == 0) ? DATA_W'((n + c) % 128) : DATA_W'($urandom);
            bus.wr_valid = v;
            bus.wr_data  = d;
            if (bus.wr_ready !== 1'b1) ready_bad++;
            acc = v && bus.wr_ready;
            tick();
            if (acc) begin
                for (int c = 0; c < NUM_CH; c++) mdl[n][c] = d[c*DATA_W +: DATA_W];
                n++;
            end
            cyc++;
        end
        bus.wr_valid = 1'b0;
        checks++; if (n != limit) begin errors++; $display("FAIL fill_count got %0d want %0d", n, limit); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL fill_wr_ready low cycles got %0d want 0", ready_bad); end
        checks++; if (bus.map_ready !== (limit == PIX_CNT)) begin errors++; $display("FAIL fill_map_ready got %b want %b", bus.map_ready, limit == PIX_CNT); end
        checks++; if (bus.wr_ready !== (limit != PIX_CNT)) begin errors++; $display("FAIL fill_wr_ready_after got %b want %b", bus.wr_ready, limit != PIX_CNT); end
    endtask

    task automatic read1(input int row, input int col, input int chan, output logic [RD_W-1:0] got);
        logic [RD_W-1:0] exp;
        logic last;
        exp  = exp_rd(row, col);
        last = (row == MAX_COL) && (col == MAX_COL) && (chan == NUM_CH - 1);
        if (ERR_EN && (row > MAX_COL || col > MAX_COL)) exp_err = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_row  = IDX_W'(row);
        bus.rd_col  = IDX_W'(col);
        bus.rd_chan = IDX_W'(chan);
        tick();
        bus.rd_en = 1'b0;
        got = bus.rd_data;
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL read_valid r%0d c%0d got %b want 1", row, col, bus.rd_valid); end
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL read_data r%0d c%0d got %h want %h", row, col, bus.rd_data, exp); end
        checks++; if (bus.frame_done !== last) begin errors++; $display("FAIL read_frame_done r%0d c%0d got %b want %b", row, col, bus.frame_done, last); end
        checks++; if (bus.map_ready !== !last) begin errors++; $display("FAIL read_map_ready r%0d c%0d got %b want %b", row, col, bus.map_ready, !last); end
        checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL read_err r%0d c%0d got %b want %b", row, col, bus.err, exp_err); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b want 0", bus.rd_valid); end
        checks++; if (bus.rd_data !== exp) begin errors++; $display("FAIL hold_data got %h want %h", bus.rd_data, exp); end
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", bus.frame_done); end
    endtask

    task automatic test_read_basic();
        logic [RD_W-1:0] got;
        read1(0, 0, 0, got);
        checks++; if (got[3*2*DATA_W +: 2*DATA_W] !== 16'h0403) begin errors++; $display("FAIL pair_r0c0_ch3 got %h want 0403", got[3*2*DATA_W +: 2*DATA_W]); end
        read1(5, 12, 0, got);
        checks++; if (got[0 +: 2*DATA_W] !== 16'h004d) begin errors++; $display("FAIL pair_r5c12_ch0 got %h want 004d", got[0 +: 2*DATA_W]); end
    endtask

    task automatic test_dense_sweep();
        int shown = 0;
        int pulses = 0;
        logic last;
        for (int r = 0; r <= MAX_COL; r++) begin
            for (int c = 0; c <= MAX_COL; c++) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    last = (r == MAX_COL) && (c == MAX_COL) && (ch == NUM_CH - 1);
                    bus.rd_en   = 1'b1;
                    bus.rd_row  = IDX_W'(r);
                    bus.rd_col  = IDX_W'(c);
                    bus.rd_chan = IDX_W'(ch);
                    tick();
                    if (bus.frame_done === 1'b1) pulses++;
                    checks++;
                    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rd(r, c) || bus.frame_done !== last) begin
                        errors++;
                        if (shown < 8) $display("FAIL sweep r%0d c%0d ch%0d got v%b fd%b %h want fd%b %h",
                                                r, c, ch, bus.rd_valid, bus.frame_done, bus.rd_data, last, exp_rd(r, c));
                        shown++;
                    end
                end
            end
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.map_ready !== 1'b0) begin errors++; $display("FAIL sweep_end_map_ready got %b want 0", bus.map_ready); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL sweep_end_wr_ready got %b want 1", bus.wr_ready); end
        tick();
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL sweep_pulse_width got %b want 0", bus.frame_done); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL sweep_pulse_count got %0d want 1", pulses); end
    endtask

    task automatic test_idle_read();
        bus.rd_en  = 1'b1;
        bus.rd_row = '0;
        bus.rd_col = '0;
        if (ERR_EN) exp_err = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_read_valid got %b want 0", bus.rd_valid); end
        tick();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_read_valid_late got %b want 0", bus.rd_valid); end
        checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL idle_read_err got %b want %b", bus.err, exp_err); end
    endtask

    task automatic test_bursty_serve();
        logic [RD_W-1:0] got;
        fill(1, PIX_CNT);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fresh_err got %b want 0", bus.err); end
        for (int i = 0; i < 12; i++)
            read1($urandom_range(0, MAX_COL), $urandom_range(0, MAX_COL), $urandom_range(0, NUM_CH - 2), got);
        read1(3, 13, 0, got);
        read1(13, 0, 0, got);
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = {$urandom, $urandom, $urandom, $urandom};
            if (ERR_EN) exp_err = 1'b1;
            tick();
            checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL serve_wr_ready got %b want 0", bus.wr_ready); end
        end
        bus.wr_valid = 1'b0;
        checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL serve_write_err got %b want %b", bus.err, exp_err); end
        for (int i = 0; i < 12; i++)
            read1($urandom_range(0, MAX_COL), $urandom_range(0, MAX_COL), $urandom_range(0, NUM_CH - 2), got);
        read1(0, 0, 1, got);
        read1(MAX_COL, MAX_COL, NUM_CH - 1, got);
    endtask

    task automatic test_reset_mid_fill();
        logic [RD_W-1:0] got;
        fill(2, 80);
        test_reset();
        fill(2, PIX_CNT);
        for (int i = 0; i < 24; i++)
            read1($urandom_range(0, MAX_COL), $urandom_range(0, MAX_COL), $urandom_range(0, NUM_CH - 2), got);
        read1(MAX_COL, MAX_COL - 1, NUM_CH - 1, got);
        read1(MAX_COL, MAX_COL, NUM_CH - 1, got);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_row   = '0;
        bus.rd_col   = '0;
        bus.rd_chan  = '0;
        #12;
        test_reset();
        fill(0, PIX_CNT);
        test_read_basic();
        test_dense_sweep();
        test_idle_read();
        test_reset();
        test_bursty_serve();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/feature_map_buffer.md
Name: feature_map_buffer

Overview:
- Producer/responder side of the dense layer's feature read interface.
- Captures the pooled 13x13 feature map, all channels per pixel, streamed in raster order from the pooling stage.
- Once the map is complete, signals the dense layer, then answers its row/col/channel reads with pixel pairs (col, col+1) for every channel.
- Frees itself for the next frame after the dense layer reads the last address.

Parameters:
- NUM_CH, 16, number of channels (channel index 0..NUM_CH-1; dense OC = NUM_CH-1).
- DATA_W, 8, signed feature width.
- MAX_COL, 12, last row/col index (map is (MAX_COL+1)^2 pixels).
- ADDR_W, 8, pixel address width (must hold (MAX_COL+1)^2 - 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  pooling stage presents one pixel.
- wr_data  in  NUM_CH*DATA_W  all channels of one pixel; channel c in bits [c*DATA_W +: DATA_W].
- wr_ready  out  1  buffer accepts a write this cycle.
- map_ready  out  1  full map stored; dense layer may run (drives dense start).
- rd_en  in  1  dense layer read strobe (its dense signal).
- rd_row  in  5  dense row index.
- rd_col  in  5  dense column index.
- rd_chan  in  5  dense channelCount.
- rd_data  out  NUM_CH*2*DATA_W  per channel c: [c*2*DATA_W +: DATA_W] = pixel(row,col); the next DATA_W bits = pixel(row,col+1).
- rd_valid  out  1  rd_data valid.
- frame_done  out  1  one-cycle pulse when the final read is returned.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset values: state IDLE, write counter 0, wr_ready=1, map_ready=0, rd_valid=0, rd_data=0, frame_done=0, err=0. Storage contents are not reset.
- States:
  - IDLE: wr_ready=1. The first accepted write goes to FILL.
  - FILL: wr_ready=1. Each wr_valid&&wr_ready stores wr_data at address wcnt, then increments wcnt. When the write to address (MAX_COL+1)^2-1 is accepted, go to SERVE and clear wcnt.
  - SERVE: wr_ready=0, map_ready=1 from the first SERVE cycle. After the final read is returned, go to IDLE. map_ready drops in the same cycle frame_done pulses.
- A write accepted in IDLE counts as pixel 0. A single-pixel map is not supported: (MAX_COL+1)^2 must be at least 2.
- Read path (SERVE only):
  - rd_en samples rd_row/rd_col; address = rd_row*(MAX_COL+1)+rd_col.
  - Latency is exactly 1 cycle: rd_valid(t+1) = rd_en(t).
  - When rd_col == MAX_COL, the col+1 half is 0 for all channels. There is no wrap into the next row.
  - rd_data holds its value when rd_valid=0.
- rd_chan has no effect on data, because all channels are returned every read. It is used only for completion.
- Completion: a read with rd_row=MAX_COL, rd_col=MAX_COL and rd_chan=NUM_CH-1 is the final read. frame_done pulses with its rd_valid, and the state returns to IDLE on that edge.
- rd_en outside SERVE: ignored, rd_valid stays 0.
- wr_valid in SERVE: not accepted, nothing is stored.
- rd_en and wr_valid in the same cycle cannot both be honoured, because the states are exclusive.
- Reset mid-FILL or mid-SERVE: returns immediately to IDLE. The partial frame is discarded and outputs take their reset values.
- Arithmetic: address multiply uses a constant (MAX_COL+1) sized to ADDR_W. Out-of-range row/col (> MAX_COL) reads return 0.

Optional Feature:
- Macro FEATBUF_ERR_EN.
- When defined, err goes and stays high until reset on any of:
  - wr_valid in SERVE;
  - rd_en outside SERVE;
  - rd_row or rd_col > MAX_COL while rd_en.
- When undefined, err is tied 0 and no checking logic is built.

Decomposition:
- Package cnn_pkg holds DATA_W, NUM_CH, MAX_COL, PIX_CNT=(MAX_COL+1)^2, and the state enum typedef {IDLE, FILL, SERVE}.
- One sub-module fb_ram: PIX_CNT x NUM_CH*DATA_W storage with one synchronous write port and two synchronous read ports (addr, addr+1).
- The top level holds the FSM, counters, edge-column masking and completion logic.

Test Plan:
- Fill the map with pixel p, channel c = (p+c) mod 128 (169 writes, wr_valid continuous) -> map_ready rises on the cycle after write 168; wr_ready=0 from then.
- Read row=0, col=0 -> after 1 cycle rd_valid=1; channel 3 pair = (3, 4). Read row=5, col=12 -> channel 0 pair = (77, 0).
- Full dense-order sweep ending at row=12, col=12, chan=15 -> frame_done single pulse, map_ready=0, wr_ready=1 in the next cycle.
- Bursty writes with wr_valid toggling every other cycle -> exactly 169 accepted. Extra wr_valid in SERVE -> data unchanged on readback; err=1 only with FEATBUF_ERR_EN.
- Assert rst at write 80, then refill with new data -> readback shows only the new frame values; all outputs are at reset values during rst.
- rd_en in IDLE -> rd_valid stays 0. Under FEATBUF_ERR_EN, rd_col=13 in SERVE -> rd_data=0 and err=1.
